decode_branch_unit: RTL

Parametrised decode-stage branch/hazard unit placed between the IF/ID register and the ID/EX register. It holds the N/Z/V flag register and resolves B and BR branches in decode against eight condition codes. It detects BR-register and flag hazards against any number of in-flight producers, and issues a registered redirect/flush. Non-branch instructions are passed to the ID/EX side through a registered valid/instruction/PC stage; a squash state drops the wrong-path instruction after a taken branch.

---
 rtl/decode_branch_unit_if.sv | 27 ++
 rtl/decode_branch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/decode_branch_unit_if.sv
// Decode-stage bus between IF/ID and ID/EX: the instruction coming in,
// the decoded slot going out, and the branch redirect back to fetch.
interface decode_branch_unit_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   instr;
  logic [DW-1:0] pc;
  logic [DW-1:0] rs_data;
  logic          out_valid;
  logic [15:0]   out_instr;
  logic [DW-1:0] out_pc;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          flush;

  modport master (
    output in_valid, instr, pc, rs_data,
    input  in_ready, out_valid, out_instr, out_pc, redirect, redirect_pc, flush
  );

  modport slave (
    input  in_valid, instr, pc, rs_data,
    output in_ready, out_valid, out_instr, out_pc, redirect, redirect_pc, flush
  );
endinterface

// File: rtl/decode_branch_unit.sv
// Decode-stage branch/hazard unit: owns the N/Z/V flags, resolves B/BR in
// decode, stalls on register/flag hazards and squashes the wrong-path slot.
module decode_branch_unit #(
  parameter int DW          = 16,
  parameter int RA          = 4,
  parameter int NPROD       = 2,
  parameter bit FLAG_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  decode_branch_unit_if.slave bus,
  input  logic [2:0]          flags_in,
  input  logic [2:0]          flag_wr_en,
  input  logic                flag_busy,
  input  logic [NPROD-1:0]    prod_wr,
  input  logic [NPROD*RA-1:0] prod_dst,
  output logic                stall,
  output logic [2:0]          flags,
  output logic [15:0]         stall_cycles
);
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;
  localparam logic [15:0] NOP      = 16'hE000;

  logic [0:0]    r_state;
  logic [2:0]    r_flags;
  logic [15:0]   r_stall_cycles;
  logic          r_out_valid;
  logic [15:0]   r_out_instr;
  logic [DW-1:0] r_out_pc;
  logic          r_redirect;
  logic [DW-1:0] r_redirect_pc;

  logic          w_is_b, w_is_br, w_is_branch;
  logic [2:0]    w_cond;
  logic [2:0]    w_fe;
  logic          w_n, w_z, w_v;
  logic          w_cond_true;
  logic          w_br_hit;
  logic          w_hazard;
  logic          w_accept;
  logic          w_taken;
  logic [DW-1:0] w_off;
  logic [DW-1:0] w_target;

  assign w_is_b      = (bus.instr[15:12] == 4'hC);
  assign w_is_br     = (bus.instr[15:12] == 4'hD);
  assign w_is_branch = w_is_b | w_is_br;
  assign w_cond      = bus.instr[11:9];

  // Bypass forwards only the flag bits being written this cycle.
  assign w_fe = FLAG_BYPASS ? ((flag_wr_en & flags_in) | (~flag_wr_en & r_flags)) : r_flags;
  assign w_n  = w_fe[2];
  assign w_z  = w_fe[1];
  assign w_v  = w_fe[0];

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      3'b000:  w_cond_true = !w_z;
      3'b001:  w_cond_true = w_z;
      3'b010:  w_cond_true = !w_z && !w_n;
      3'b011:  w_cond_true = w_n;
      3'b100:  w_cond_true = w_z || (!w_z && !w_n);
      3'b101:  w_cond_true = w_n || w_z;
      3'b110:  w_cond_true = w_v;
      default: w_cond_true = 1'b1;
    endcase
  end

  always_comb begin
    w_br_hit = 1'b0;
    for (int unsigned i = 0; i < NPROD; i++) begin
      if (prod_wr[i] && (prod_dst[i*RA +: RA] == bus.instr[7:4]))
        w_br_hit = 1'b1;
    end
  end

  assign w_off    = {{(DW-9){bus.instr[8]}}, bus.instr[8:0]};
  assign w_target = w_is_br ? bus.rs_data
                            : bus.pc + {{(DW-2){1'b0}}, 2'b10} + {w_off[DW-2:0], 1'b0};

  assign w_hazard = (r_state == ST_RUN) && bus.in_valid &&
                    ((w_is_br && w_br_hit) ||
                     (w_is_branch && (w_cond != 3'b111) && flag_busy));
  assign w_accept = (r_state == ST_RUN) && bus.in_valid && !w_hazard;
  assign w_taken  = w_accept && w_is_branch && w_cond_true;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_flags        <= '0;
      r_stall_cycles <= '0;
      r_out_valid    <= 1'b0;
      r_out_instr    <= NOP;
      r_out_pc       <= '0;
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (flag_wr_en[i]) r_flags[i] <= flags_in[i];
      end
      if (w_hazard && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      r_out_valid <= w_accept && !w_is_branch;
      r_out_instr <= (w_accept && !w_is_branch) ? bus.instr : NOP;
      if (w_accept && !w_is_branch) r_out_pc <= bus.pc;
      r_redirect <= w_taken;
      if (w_taken) r_redirect_pc <= w_target;
      r_state <= w_taken ? ST_SQUASH : ST_RUN;
    end
  end

  assign stall           = w_hazard;
  assign bus.in_ready    = (r_state == ST_SQUASH) ? 1'b1 : !w_hazard;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out_instr;
  assign bus.out_pc      = r_out_pc;
  assign bus.redirect    = r_redirect;
  assign bus.flush       = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;
  assign flags           = r_flags;
  assign stall_cycles    = r_stall_cycles;
endmodule
